// File: rtl/boot_loader.sv
// Boot loader: synchronises the slow external programming pins and writes the
// received nibbles into program memory through the control unit's loader port.
module boot_loader #(
    parameter int REGISTER_WIDTH       = 4,
    parameter int MEMORY_ADDRESS_WIDTH = 4,
    parameter int SETTLE_CYCLES        = 8
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            prog_req_i,
    input  logic                            nibble_valid_i,
    input  logic [REGISTER_WIDTH-1:0]       nibble_i,
    output logic                            bl_programm_o,
    output logic                            bl_write_en_mem_o,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] bl_address_o,
    output logic [REGISTER_WIDTH-1:0]       bl_data_o,
    output logic                            ready_o,
    output logic                            done_o
);

    localparam int SC_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_ARMED  = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                          state_r;
    state_t                          next_state_s;
    logic                            prog_meta_r;
    logic                            prog_s_r;
    logic                            val_meta_r;
    logic                            val_s_r;
    logic                            val_d_r;
    logic                            val_edge_s;
    logic [MEMORY_ADDRESS_WIDTH-1:0] addr_r;
    logic [REGISTER_WIDTH-1:0]       data_r;
    logic [SC_W-1:0]                 settle_r;
    logic                            programm_s;
    logic                            write_s;
    logic                            ready_s;
    logic                            done_s;
    logic                            programm_r;
    logic                            write_r;
    logic                            ready_r;
    logic                            done_r;

    assign val_edge_s = val_s_r & ~val_d_r;

    // Two-flop synchronisers for the asynchronous pins plus the edge-detect delay.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            prog_meta_r <= 1'b0;
            prog_s_r    <= 1'b0;
            val_meta_r  <= 1'b0;
            val_s_r     <= 1'b0;
            val_d_r     <= 1'b0;
        end else begin
            prog_meta_r <= prog_req_i;
            prog_s_r    <= prog_meta_r;
            val_meta_r  <= nibble_valid_i;
            val_s_r     <= val_meta_r;
            val_d_r     <= val_s_r;
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a dropped request beats a simultaneous nibble edge.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (prog_s_r) next_state_s = ST_SETTLE;
                else          next_state_s = ST_IDLE;
            end
            ST_SETTLE: begin
                if (!prog_s_r)                                  next_state_s = ST_IDLE;
                else if (settle_r == SC_W'(SETTLE_CYCLES - 1))  next_state_s = ST_ARMED;
                else                                            next_state_s = ST_SETTLE;
            end
            ST_ARMED: begin
                if (!prog_s_r)       next_state_s = ST_IDLE;
                else if (val_edge_s) next_state_s = ST_WRITE;
                else                 next_state_s = ST_ARMED;
            end
            ST_WRITE: begin
                if (addr_r == {MEMORY_ADDRESS_WIDTH{1'b1}}) next_state_s = ST_DONE;
                else if (!prog_s_r)                         next_state_s = ST_IDLE;
                else                                        next_state_s = ST_ARMED;
            end
            ST_DONE: begin
                if (!prog_s_r) next_state_s = ST_IDLE;
                else           next_state_s = ST_DONE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs track the state register.
    always_comb begin
        programm_s = 1'b0;
        write_s    = 1'b0;
        ready_s    = 1'b0;
        done_s     = 1'b0;
        case (next_state_s)
            ST_SETTLE: programm_s = 1'b1;
            ST_ARMED: begin
                programm_s = 1'b1;
                ready_s    = 1'b1;
            end
            ST_WRITE: begin
                programm_s = 1'b1;
                write_s    = 1'b1;
            end
            ST_DONE:   done_s = 1'b1;
            default:   programm_s = 1'b0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            programm_r <= 1'b0;
            write_r    <= 1'b0;
            ready_r    <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            programm_r <= programm_s;
            write_r    <= write_s;
            ready_r    <= ready_s;
            done_r     <= done_s;
        end
    end

    // Datapath: address/settle counters and nibble capture; address wraps after the last word.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_r   <= {MEMORY_ADDRESS_WIDTH{1'b0}};
            data_r   <= {REGISTER_WIDTH{1'b0}};
            settle_r <= {SC_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (prog_s_r) begin
                        addr_r   <= {MEMORY_ADDRESS_WIDTH{1'b0}};
                        settle_r <= {SC_W{1'b0}};
                    end
                end
                ST_SETTLE: settle_r <= settle_r + SC_W'(1);
                ST_ARMED: begin
                    if (prog_s_r && val_edge_s) data_r <= nibble_i;
                end
                ST_WRITE: addr_r <= addr_r + MEMORY_ADDRESS_WIDTH'(1);
                default:  settle_r <= settle_r;
            endcase
        end
    end

    assign bl_programm_o     = programm_r;
    assign bl_write_en_mem_o = write_r;
    assign ready_o           = ready_r;
    assign done_o            = done_r;
    assign bl_address_o      = addr_r;
    assign bl_data_o         = data_r;

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader: logs every write pulse and
// compares the log and status outputs against hand-computed expectations.
module tb_boot_loader;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       prog_req_i = 1'b0;
    logic       nibble_valid_i = 1'b0;
    logic [3:0] nibble_i = 4'h0;
    logic       bl_programm_o;
    logic       bl_write_en_mem_o;
    logic [3:0] bl_address_o;
    logic [3:0] bl_data_o;
    logic       ready_o;
    logic       done_o;

    int checks = 0;
    int errors = 0;
    logic [3:0] wr_addr[$];
    logic [3:0] wr_data[$];
    int   double_pulse = 0;
    logic prev_we = 1'b0;

    boot_loader #(.REGISTER_WIDTH(4), .MEMORY_ADDRESS_WIDTH(4), .SETTLE_CYCLES(8)) dut (
        .clk_i(clk), .reset_i(reset_i), .prog_req_i(prog_req_i),
        .nibble_valid_i(nibble_valid_i), .nibble_i(nibble_i),
        .bl_programm_o(bl_programm_o), .bl_write_en_mem_o(bl_write_en_mem_o),
        .bl_address_o(bl_address_o), .bl_data_o(bl_data_o),
        .ready_o(ready_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    // Write-pulse logger, sampled on the inactive edge.
    always @(negedge clk) begin
        if (bl_write_en_mem_o) begin
            wr_addr.push_back(bl_address_o);
            wr_data.push_back(bl_data_o);
            if (prev_we) double_pulse++;
        end
        prev_we = bl_write_en_mem_o;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_value(tag, 32'(ready_o), 32'd1);
    endtask

    task automatic send_nibble(input logic [3:0] v);
        nibble_i       = v;
        nibble_valid_i = 1'b1;
        cycles(6);
        nibble_valid_i = 1'b0;
        cycles(6);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    function automatic logic [31:0] outs();
        return {24'd0, bl_programm_o, bl_write_en_mem_o, ready_o, done_o, bl_address_o | bl_data_o};
    endfunction

    initial begin
        int n;
        logic [3:0] v;

        // Reset held with active pins: everything stays quiet.
        prog_req_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            nibble_valid_i = ~nibble_valid_i;
            @(negedge clk);
            check_value("reset_outputs", outs(), 32'd0);
        end
        nibble_valid_i = 1'b0;
        reset_i = 1'b0;
        n = 0;
        while (!bl_programm_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_value("programm_rise_latency", 32'(n), 32'd3);
        check_value("settle_not_ready", 32'(ready_o), 32'd0);

        // Full load F..0.
        clear_log();
        wait_ready("full_ready");
        for (int i = 0; i < 16; i++) begin
            v = 4'(15 - i);
            send_nibble(v);
        end
        check_value("full_count", 32'(wr_addr.size()), 32'd16);
        for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
            check_value($sformatf("full_addr%0d", i), 32'(wr_addr[i]), 32'(i));
            check_value($sformatf("full_data%0d", i), 32'(wr_data[i]), 32'(15 - i));
        end
        check_value("full_done", 32'(done_o), 32'd1);
        check_value("full_programm", 32'(bl_programm_o), 32'd0);
        check_value("full_ready_low", 32'(ready_o), 32'd0);
        check_value("full_addr_wrap", 32'(bl_address_o), 32'd0);
        send_nibble(4'h9);
        check_value("done_ignores_edge", 32'(wr_addr.size()), 32'd16);
        prog_req_i = 1'b0;
        cycles(6);
        check_value("done_exit", 32'(done_o), 32'd0);

        // Partial load then request drop.
        clear_log();
        prog_req_i = 1'b1;
        wait_ready("partial_ready");
        send_nibble(4'h3);
        send_nibble(4'h9);
        send_nibble(4'hA);
        prog_req_i = 1'b0;
        n = 0;
        while (bl_programm_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_value("partial_fall_window", 32'(n >= 2 && n <= 3), 32'd1);
        check_value("partial_count", 32'(wr_addr.size()), 32'd3);
        if (wr_addr.size() == 3) begin
            check_value("partial_w0", {wr_addr[0], wr_data[0]}, 32'h03);
            check_value("partial_w1", {wr_addr[1], wr_data[1]}, 32'h19);
            check_value("partial_w2", {wr_addr[2], wr_data[2]}, 32'h2A);
        end
        check_value("partial_done", 32'(done_o), 32'd0);
        cycles(4);

        // Nibble during SETTLE is ignored.
        clear_log();
        prog_req_i = 1'b1;
        n = 0;
        while (!bl_programm_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        nibble_i = 4'hC;
        nibble_valid_i = 1'b1;
        cycles(2);
        nibble_valid_i = 1'b0;
        wait_ready("settle_ready");
        cycles(4);
        check_value("settle_no_write", 32'(wr_addr.size()), 32'd0);
        send_nibble(4'h6);
        check_value("settle_after_count", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1)
            check_value("settle_after_w0", {wr_addr[0], wr_data[0]}, 32'h06);
        prog_req_i = 1'b0;
        cycles(6);

        // Held valid yields a single write.
        clear_log();
        prog_req_i = 1'b1;
        wait_ready("held_ready");
        nibble_i = 4'h5;
        nibble_valid_i = 1'b1;
        cycles(40);
        nibble_valid_i = 1'b0;
        cycles(6);
        check_value("held_count", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1)
            check_value("held_w0", {wr_addr[0], wr_data[0]}, 32'h05);
        prog_req_i = 1'b0;
        cycles(6);

        // Reset mid-session, then restart.
        clear_log();
        prog_req_i = 1'b1;
        wait_ready("mid_ready");
        for (int i = 1; i <= 5; i++) send_nibble(4'(i));
        check_value("mid_count", 32'(wr_addr.size()), 32'd5);
        reset_i = 1'b1;
        #1;
        check_value("mid_reset_outputs", outs(), 32'd0);
        cycles(2);
        reset_i = 1'b0;
        wait_ready("mid_restart_ready");
        send_nibble(4'h7);
        check_value("mid_restart_count", 32'(wr_addr.size()), 32'd6);
        if (wr_addr.size() == 6)
            check_value("mid_restart_w", {wr_addr[5], wr_data[5]}, 32'h07);
        prog_req_i = 1'b0;
        cycles(6);

        check_value("single_cycle_pulses", 32'(double_pulse), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
